// File: rtl/isp_hist_reader.sv
// Purpose: sweeps the 4-channel Bayer histogram read port and reduces it to per-channel total/under/over/peak.
// Latency: start sampled at cycle 0 -> addresses at cycles 1..4*2^BITS -> out_done at 4*2^BITS + RD_LAT + 1.
// Backpressure: none; the read port is assumed always ready and start while busy is dropped (no queuing).
//
// Ports:
//   pclk, rst_n            clock (also the histogram RAM clock), async active-low reset
//   start                  one-cycle sweep request, honoured only when idle
//   lo_thresh, hi_thresh   bins <= lo count as under-exposed, bins >= hi as over-exposed (latched at start)
//   hist_out, hist_addr    read enable and {channel[1:0], bin} address towards the statistics RAM
//   hist_data              bin count returned RD_LAT cycles after hist_addr
//   busy, out_done         sweep in progress / one-cycle pulse when out_* were refreshed
//   out_total/under/over   per-channel saturating sums, channel n at [n*OUT_BITS +: OUT_BITS]
//   out_peak               per-channel bin index of the largest count, channel n at [n*BITS +: BITS]
module isp_hist_reader #(
    parameter int BITS     = 8,
    parameter int OUT_BITS = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BITS-1:0]       lo_thresh,
    input  logic [BITS-1:0]       hi_thresh,
    output logic                  hist_out,
    output logic [BITS+1:0]       hist_addr,
    input  logic [OUT_BITS-1:0]   hist_data,
    output logic                  busy,
    output logic                  out_done,
    output logic [4*OUT_BITS-1:0] out_total,
    output logic [4*OUT_BITS-1:0] out_under,
    output logic [4*OUT_BITS-1:0] out_over,
    output logic [4*BITS-1:0]     out_peak
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam logic [BITS+1:0] ADDR_LAST  = '1;
    localparam logic [2:0]      DRAIN_LAST = 3'(RD_LAT - 1);

    state_t          state_q, state_d;
    logic            accept;      // start taken this cycle
    logic            finish;      // last delayed sample consumed this cycle
    logic [BITS+1:0] addr_q;
    logic [2:0]      drain_cnt_q;
    logic [BITS-1:0] lo_q, hi_q;

    // Delay line carrying {valid, channel, bin} alongside each address.
    logic [RD_LAT-1:0] pipe_vld;
    logic [1:0]        pipe_ch  [RD_LAT];
    logic [BITS-1:0]   pipe_bin [RD_LAT];

    logic            smp_vld;
    logic [1:0]      smp_ch;
    logic [BITS-1:0] smp_bin;

    // Working accumulators (current value and next value).
    logic [OUT_BITS-1:0] tot_q [4], tot_d [4];
    logic [OUT_BITS-1:0] und_q [4], und_d [4];
    logic [OUT_BITS-1:0] ovr_q [4], ovr_d [4];
    logic [OUT_BITS-1:0] pmax_q[4], pmax_d[4];
    logic [BITS-1:0]     pbin_q[4], pbin_d[4];

    function automatic logic [OUT_BITS-1:0] sat_add(input logic [OUT_BITS-1:0] a,
                                                    input logic [OUT_BITS-1:0] b);
        logic [OUT_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[OUT_BITS] ? {OUT_BITS{1'b1}} : s[OUT_BITS-1:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        finish    = 1'b0;
        hist_out  = 1'b0;
        busy      = 1'b1;
        out_done  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = SWEEP;
                    accept  = 1'b1;
                end
            end
            SWEEP: begin
                hist_out = 1'b1;
                if (addr_q == ADDR_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                out_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hist_addr = addr_q;

    // Address counter, drain counter and latched thresholds.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            drain_cnt_q <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else begin
            if (accept) begin
                lo_q <= lo_thresh;
                hi_q <= hi_thresh;
            end
            // Address stops at the last bin (held through DRAIN/DONE), back to 0 once idle.
            case (state_q)
                SWEEP:   if (addr_q != ADDR_LAST) addr_q <= addr_q + 1'b1;
                DRAIN:   addr_q <= addr_q;
                default: addr_q <= '0;
            endcase
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : 3'd0;
        end
    end

    // ---------------- read-latency alignment ----------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_ch[i]  <= '0;
                pipe_bin[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= hist_out;
            pipe_ch[0]  <= addr_q[BITS+1:BITS];
            pipe_bin[0] <= addr_q[BITS-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_ch[i]  <= pipe_ch[i-1];
                pipe_bin[i] <= pipe_bin[i-1];
            end
        end
    end

    assign smp_vld = pipe_vld[RD_LAT-1];
    assign smp_ch  = pipe_ch[RD_LAT-1];
    assign smp_bin = pipe_bin[RD_LAT-1];

    // ---------------- accumulation ----------------
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            tot_d[c]  = tot_q[c];
            und_d[c]  = und_q[c];
            ovr_d[c]  = ovr_q[c];
            pmax_d[c] = pmax_q[c];
            pbin_d[c] = pbin_q[c];
        end
        if (smp_vld) begin
            tot_d[smp_ch] = sat_add(tot_q[smp_ch], hist_data);
            if (smp_bin <= lo_q) und_d[smp_ch] = sat_add(und_q[smp_ch], hist_data);
            if (smp_bin >= hi_q) ovr_d[smp_ch] = sat_add(ovr_q[smp_ch], hist_data);
            // Bin 0 restarts the channel's peak search; strict > keeps the lowest bin on ties.
            if ((smp_bin == '0) || (hist_data > pmax_q[smp_ch])) begin
                pmax_d[smp_ch] = hist_data;
                pbin_d[smp_ch] = smp_bin;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                tot_q[c]  <= '0;
                und_q[c]  <= '0;
                ovr_q[c]  <= '0;
                pmax_q[c] <= '0;
                pbin_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < 4; c++) begin
                tot_q[c]  <= '0;
                und_q[c]  <= '0;
                ovr_q[c]  <= '0;
                pmax_q[c] <= '0;
                pbin_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                tot_q[c]  <= tot_d[c];
                und_q[c]  <= und_d[c];
                ovr_q[c]  <= ovr_d[c];
                pmax_q[c] <= pmax_d[c];
                pbin_q[c] <= pbin_d[c];
            end
        end
    end

    // Results take the next-state values so the final sample lands in the same
    // cycle out_done is raised.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_total <= '0;
            out_under <= '0;
            out_over  <= '0;
            out_peak  <= '0;
        end else if (finish) begin
            for (int c = 0; c < 4; c++) begin
                out_total[c*OUT_BITS +: OUT_BITS] <= tot_d[c];
                out_under[c*OUT_BITS +: OUT_BITS] <= und_d[c];
                out_over[c*OUT_BITS +: OUT_BITS]  <= ovr_d[c];
                out_peak[c*BITS +: BITS]          <= pbin_d[c];
            end
        end
    end

endmodule
